// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and op classification for the sequential ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DIV = 4'd4;
  localparam logic [3:0] OP_REM = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_NOR = 4'd12;
  localparam logic [3:0] OP_SHH = 4'd14;
  localparam logic [3:0] OP_SLE = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared radix-2 datapath: shift-add multiply and restoring divide on operand
// magnitudes, with sign correction applied to the raw result in the FIX state.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_src1,
  input  logic [WIDTH-1:0] i_src2,
  output logic             o_idle,
  output logic             o_fin,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;   // product accumulator / partial remainder
  logic [WIDTH-1:0] r_a;     // multiplicand / divisor magnitude
  logic [WIDTH-1:0] r_b;     // multiplier / dividend shifting into quotient
  logic             r_mul;
  logic             r_rem;
  logic             r_neg;
  logic             r_dz;

  logic             w_s1;
  logic             w_s2;
  logic [WIDTH-1:0] w_mag1;
  logic [WIDTH-1:0] w_mag2;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_raw;

  assign w_s1    = i_src1[WIDTH-1];
  assign w_s2    = i_src2[WIDTH-1];
  assign w_mag1  = w_s1 ? -i_src1 : i_src1;
  assign w_mag2  = w_s2 ? -i_src2 : i_src2;
  assign w_shift = {r_acc, r_b[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_a};

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_mul   <= 1'b0;
      r_rem   <= 1'b0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_acc   <= '0;
            r_a     <= w_mag2;
            r_b     <= w_mag1;
            r_mul   <= (i_op == OP_MUL);
            r_rem   <= (i_op == OP_REM);
            r_neg   <= (i_op == OP_REM) ? w_s1 : (w_s1 ^ w_s2);
            r_dz    <= (i_src2 == '0);
            r_cnt   <= CW'(WIDTH - 1);
            r_state <= CALC;
          end
        end
        CALC: begin
          if (r_mul) begin
            if (r_b[0]) r_acc <= r_acc + r_a;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end else if (!w_diff[WIDTH]) begin
            r_acc <= w_diff[WIDTH-1:0];
            r_b   <= {r_b[WIDTH-2:0], 1'b1};
          end else begin
            r_acc <= w_shift[WIDTH-1:0];
            r_b   <= {r_b[WIDTH-2:0], 1'b0};
          end
          if (r_cnt == '0) r_state <= FIX;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        FIX:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Divide by zero yields an all-ones quotient; the remainder path already
  // reproduces the dividend through normal sign correction.
  assign w_raw    = (r_mul || r_rem) ? r_acc : r_b;
  assign o_result = (r_dz && !r_mul && !r_rem) ? '1 : (r_neg ? -w_raw : w_raw);
  assign o_idle   = (r_state == IDLE);
  assign o_fin    = (r_state == FIX);

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops resolve on the accept edge, MUL/DIV/REM
// run through the iterative datapath; result/zero/done are registered here.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             done_o
);

  logic             w_accept;
  logic             w_multi;
  logic             w_idle;
  logic             w_fin;
  logic [WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_single;

  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_done;

  assign w_multi  = is_multicycle(ctrl_i);
  assign w_accept = valid_i && w_idle;
  assign ready_o  = w_idle;

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .i_clk    (clk_i),
    .i_rst    (rst_i),
    .i_start  (w_accept && w_multi),
    .i_op     (ctrl_i),
    .i_src1   (src1_i),
    .i_src2   (src2_i),
    .o_idle   (w_idle),
    .o_fin    (w_fin),
    .o_result (w_iter_res)
  );

  // NOTE: the default assignment ahead of the case keeps this block free of
  // inferred latches for unlisted opcodes.
  always_comb begin
    w_single = '0;
    case (ctrl_i)
      OP_AND:  w_single = src1_i & src2_i;
      OP_OR:   w_single = src1_i | src2_i;
      OP_ADD:  w_single = src1_i + src2_i;
      OP_SUB:  w_single = src1_i - src2_i;
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      OP_SRA:  w_single = $signed(src1_i) >>> src2_i[SHW-1:0];
      OP_NOR:  w_single = ~(src1_i | src2_i);
      OP_SHH:  w_single = src2_i << (WIDTH / 2);
      OP_SLE:  w_single = {{(WIDTH-1){1'b0}}, ($signed(src1_i) <= $signed(src2_i))};
      default: w_single = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fin) begin
        r_result <= w_iter_res;
        r_zero   <= (w_iter_res == '0);
        r_done   <= 1'b1;
      end else if (w_accept && !w_multi) begin
        r_result <= w_single;
        r_zero   <= (w_single == '0);
        r_done   <= 1'b1;
      end
    end
  end

  assign result_o = r_result;
  assign zero_o   = r_zero;
  assign done_o   = r_done;

endmodule
